// File: rtl/video_pkg.sv
// Shared constants for the scanline post-processing stage.
package video_pkg;

  // Dim strength codes carried on the scanlines input and in the latched mode.
  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_25  = 2'd1;
  localparam logic [1:0] SL_50  = 2'd2;
  localparam logic [1:0] SL_75  = 2'd3;

  // Input-to-output latency of hs, de and colour, in clk_sys cycles.
  localparam int PIPE_LAT = 2;

endpackage

// File: rtl/video_dim.sv
// Single colour channel attenuator: truncating shifts, result never exceeds c.
module video_dim
  import video_pkg::*;
#(
  parameter int COLOR_DEPTH = 4
) (
  input  logic [COLOR_DEPTH-1:0] c,
  input  logic [1:0]             m,
  output logic [COLOR_DEPTH-1:0] y
);

  // Select the attenuated value for the requested strength.
  always_comb begin
    y = c;
    case (m)
      SL_25:   y = c - (c >> 2);
      SL_50:   y = c >> 1;
      SL_75:   y = c >> 2;
      default: y = c;
    endcase
  end

endmodule

// File: rtl/video_scanlines.sv
// CRT scanline emulation after the line doubler: dims odd output lines,
// delays vsync by one line, and produces a registered data enable.
module video_scanlines
  import video_pkg::*;
#(
  parameter int COLOR_DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [1:0]             scanlines,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   hbl_in,
  input  logic                   vbl_in,
  input  logic [COLOR_DEPTH-1:0] r_in,
  input  logic [COLOR_DEPTH-1:0] g_in,
  input  logic [COLOR_DEPTH-1:0] b_in,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   de_out,
  output logic [COLOR_DEPTH-1:0] r_out,
  output logic [COLOR_DEPTH-1:0] g_out,
  output logic [COLOR_DEPTH-1:0] b_out,
  output logic                   line_odd
);

  logic                   hs1, vs1, hbl1, vbl1;
  logic [COLOR_DEPTH-1:0] r1, g1, b1;
  logic                   hs1_prev, vs1_prev;
  logic                   vs_hold;
  logic [1:0]             mode_l;

  logic                   line_start, vs_edge, de1, dim_en;
  logic                   odd_nxt, vs_nxt;
  logic [COLOR_DEPTH-1:0] r_dim, g_dim, b_dim;
  logic [COLOR_DEPTH-1:0] r_nxt, g_nxt, b_nxt;

  // Stage 1: register the incoming bus; hs/vs history feeds edge detection.
  // Blanks reset high so nothing is flagged as active right after reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hs1      <= 1'b1;
      vs1      <= 1'b1;
      hbl1     <= 1'b1;
      vbl1     <= 1'b1;
      r1       <= {COLOR_DEPTH{1'b0}};
      g1       <= {COLOR_DEPTH{1'b0}};
      b1       <= {COLOR_DEPTH{1'b0}};
      hs1_prev <= 1'b1;
      vs1_prev <= 1'b1;
    end else begin
      hs1      <= hs_in;
      vs1      <= vs_in;
      hbl1     <= hbl_in;
      vbl1     <= vbl_in;
      r1       <= r_in;
      g1       <= g_in;
      b1       <= b_in;
      hs1_prev <= hs1;
      vs1_prev <= vs1;
    end
  end

  assign line_start = hs1_prev & ~hs1;
  assign vs_edge    = vs1_prev ^ vs1;
  assign de1        = ~(hbl1 | vbl1);
  assign dim_en     = enable & line_odd & (mode_l != SL_OFF);

  video_dim #(.COLOR_DEPTH(COLOR_DEPTH)) u_dim_r (.c(r1), .m(mode_l), .y(r_dim));
  video_dim #(.COLOR_DEPTH(COLOR_DEPTH)) u_dim_g (.c(g1), .m(mode_l), .y(g_dim));
  video_dim #(.COLOR_DEPTH(COLOR_DEPTH)) u_dim_b (.c(b1), .m(mode_l), .y(b_dim));

  // Next parity, vsync and colour; a vsync edge overrides a coincident line start.
  always_comb begin
    odd_nxt = line_odd;
    vs_nxt  = vs_out;
    r_nxt   = r1;
    g_nxt   = g1;
    b_nxt   = b1;

    if (vs_edge) begin
      odd_nxt = 1'b0;
    end else if (line_start) begin
      odd_nxt = ~line_odd;
    end else begin
      odd_nxt = line_odd;
    end

    if (!enable) begin
      vs_nxt = vs1;
    end else if (line_start) begin
      vs_nxt = vs_hold;
    end else begin
      vs_nxt = vs_out;
    end

    if (!de1) begin
      r_nxt = {COLOR_DEPTH{1'b0}};
      g_nxt = {COLOR_DEPTH{1'b0}};
      b_nxt = {COLOR_DEPTH{1'b0}};
    end else if (dim_en) begin
      r_nxt = r_dim;
      g_nxt = g_dim;
      b_nxt = b_dim;
    end else begin
      r_nxt = r1;
      g_nxt = g1;
      b_nxt = b1;
    end
  end

  // Stage 2 outputs plus line-rate state (parity, vsync hold, latched dim mode).
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hs_out   <= 1'b1;
      vs_out   <= 1'b1;
      de_out   <= 1'b0;
      r_out    <= {COLOR_DEPTH{1'b0}};
      g_out    <= {COLOR_DEPTH{1'b0}};
      b_out    <= {COLOR_DEPTH{1'b0}};
      line_odd <= 1'b0;
      vs_hold  <= 1'b1;
      mode_l   <= SL_OFF;
    end else begin
      hs_out   <= hs1;
      vs_out   <= vs_nxt;
      de_out   <= de1;
      r_out    <= r_nxt;
      g_out    <= g_nxt;
      b_out    <= b_nxt;
      line_odd <= odd_nxt;
      if (line_start) begin
        vs_hold <= vs1;
        mode_l  <= scanlines;
      end
    end
  end

endmodule

// File: tb/tb_video_scanlines.sv
// Self-checking bench for video_scanlines: a frame-level reference model is
// compared every cycle, plus hand-computed spot values along the test plan.
module tb_video_scanlines;

  logic       clk_sys = 1'b0;
  logic       reset_n, enable;
  logic [1:0] scanlines;
  logic       hs_in, vs_in, hbl_in, vbl_in;
  logic [3:0] r_in, g_in, b_in;
  logic       hs_out, vs_out, de_out, line_odd;
  logic [3:0] r_out, g_out, b_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  video_scanlines #(.COLOR_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .scanlines(scanlines),
    .hs_in(hs_in), .vs_in(vs_in), .hbl_in(hbl_in), .vbl_in(vbl_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .line_odd(line_odd)
  );

  // Reference model state: the sample taken one edge ago, the sample before
  // that (for line / vsync edges), a line counter since the last vsync edge.
  logic       s_hs, s_vs, s_hbl, s_vbl;
  logic [3:0] s_r, s_g, s_b;
  logic       p_hs, p_vs;
  int         line_cnt;
  logic [1:0] m_mode;
  logic       m_held;
  logic       e_hs, e_vs, e_de, e_odd;
  logic [3:0] e_r, e_g, e_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Attenuation as a fraction of the channel: keep ceil(3/4), floor(1/2), floor(1/4).
  function automatic logic [3:0] dimf(input logic [3:0] c, input logic [1:0] m);
    int ci;
    int v;
    ci = int'(c);
    case (m)
      2'd1:    v = (3 * ci + 3) / 4;
      2'd2:    v = ci / 2;
      2'd3:    v = ci / 4;
      default: v = ci;
    endcase
    return v[3:0];
  endfunction

  task automatic model_edge();
    logic ls, ve, de, dim;
    if (!reset_n) begin
      s_hs = 1'b1; s_vs = 1'b1; s_hbl = 1'b1; s_vbl = 1'b1;
      s_r = 4'h0; s_g = 4'h0; s_b = 4'h0;
      p_hs = 1'b1; p_vs = 1'b1;
      line_cnt = 0; m_mode = 2'd0; m_held = 1'b1;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_odd = 1'b0;
      e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
    end else begin
      ls  = p_hs && !s_hs;
      ve  = (p_vs != s_vs);
      de  = !(s_hbl || s_vbl);
      dim = enable && (line_cnt % 2 == 1) && (m_mode != 2'd0);
      e_hs = s_hs;
      e_de = de;
      e_r = !de ? 4'h0 : (dim ? dimf(s_r, m_mode) : s_r);
      e_g = !de ? 4'h0 : (dim ? dimf(s_g, m_mode) : s_g);
      e_b = !de ? 4'h0 : (dim ? dimf(s_b, m_mode) : s_b);
      if (!enable) e_vs = s_vs;
      else if (ls) e_vs = m_held;
      if (ls) begin
        m_held = s_vs;
        m_mode = scanlines;
      end
      if (ve) line_cnt = 0;
      else if (ls) line_cnt = line_cnt + 1;
      e_odd = (line_cnt % 2 == 1);
      p_hs = s_hs; p_vs = s_vs;
      s_hs = hs_in; s_vs = vs_in; s_hbl = hbl_in; s_vbl = vbl_in;
      s_r = r_in; s_g = g_in; s_b = b_in;
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs 1 time unit later.
  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    chk("hs_out",   32'(hs_out),   32'(e_hs));
    chk("vs_out",   32'(vs_out),   32'(e_vs));
    chk("de_out",   32'(de_out),   32'(e_de));
    chk("line_odd", 32'(line_odd), 32'(e_odd));
    chk("r_out",    32'(r_out),    32'(e_r));
    chk("g_out",    32'(g_out),    32'(e_g));
    chk("b_out",    32'(b_out),    32'(e_b));
  endtask

  // Line shape: 4 cycles hsync low from p=0, blank for the first 8 and last 4.
  task automatic set_pos(input int p, input int len);
    hs_in  = (p < 4) ? 1'b0 : 1'b1;
    hbl_in = (p < 8 || p >= len - 4) ? 1'b1 : 1'b0;
  endtask

  task automatic run_line(input int len, input logic [3:0] exp_r);
    for (int p = 0; p < len; p++) begin
      set_pos(p, len);
      step();
      if (p == 16) chk("line_r", 32'(r_out), 32'(exp_r));
    end
  endtask

  initial begin
    logic [31:0] rnd;
    reset_n = 1'b0; enable = 1'b1; scanlines = 2'd2;
    hs_in = 1'b1; vs_in = 1'b1; hbl_in = 1'b1; vbl_in = 1'b0;
    r_in = 4'h0; g_in = 4'h0; b_in = 4'h0;

    // Reset with random inputs for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      rnd = $urandom;
      hs_in = rnd[0]; vs_in = rnd[1]; hbl_in = rnd[2]; vbl_in = rnd[3];
      r_in = rnd[7:4]; g_in = rnd[11:8]; b_in = rnd[15:12];
      enable = rnd[16]; scanlines = rnd[18:17];
      step();
    end
    chk("rst_hs",  32'(hs_out),   32'h1);
    chk("rst_vs",  32'(vs_out),   32'h1);
    chk("rst_de",  32'(de_out),   32'h0);
    chk("rst_rgb", 32'({r_out, g_out, b_out}), 32'h0);
    chk("rst_odd", 32'(line_odd), 32'h0);

    // Release: colour appears two cycles later.
    reset_n = 1'b1; enable = 1'b1; scanlines = 2'd2;
    hs_in = 1'b1; vs_in = 1'b1; hbl_in = 1'b0; vbl_in = 1'b0;
    r_in = 4'h5; g_in = 4'h5; b_in = 4'h5;
    step();
    chk("lat_early_r", 32'(r_out), 32'h0);
    step();
    chk("lat_r", 32'(r_out), 32'h5);

    // Dimming at each strength with full-scale colour.
    r_in = 4'hF; g_in = 4'hF; b_in = 4'hF;
    run_line(32, 4'h7);
    run_line(32, 4'hF);
    run_line(32, 4'h7);
    scanlines = 2'd1;
    run_line(32, 4'hF);
    run_line(32, 4'hC);
    scanlines = 2'd3;
    run_line(32, 4'hF);
    run_line(32, 4'h3);

    // Mid-line mode change on an odd line only takes effect next odd line.
    scanlines = 2'd1;
    run_line(32, 4'hF);
    for (int p = 0; p < 32; p++) begin
      set_pos(p, 32);
      step();
      if (p == 12) begin
        chk("mid_before", 32'(r_out), 32'hC);
        scanlines = 2'd3;
      end
      if (p == 24) chk("mid_after", 32'(r_out), 32'hC);
    end
    run_line(32, 4'hF);
    run_line(32, 4'h3);

    // Vsync delay with enable=1: toggle 100 cycles into line N.
    for (int p = 0; p < 140; p++) begin
      set_pos(p, 140);
      if (p == 100) vs_in = 1'b0;
      step();
    end
    for (int p = 0; p < 140; p++) begin
      set_pos(p, 140);
      step();
      if (p == 1 || p == 139) chk("vsd_n1", 32'(vs_out), 32'h1);
    end
    for (int p = 0; p < 40; p++) begin
      set_pos(p, 40);
      step();
      if (p == 0) chk("vsd_n2_early", 32'(vs_out), 32'h1);
      if (p == 1) chk("vsd_n2", 32'(vs_out), 32'h0);
    end

    // Vsync pass-through with enable=0: two cycles after vs_in.
    enable = 1'b0;
    for (int p = 0; p < 40; p++) begin
      set_pos(p, 40);
      if (p == 20) vs_in = 1'b1;
      step();
      if (p == 20) chk("vsp_early", 32'(vs_out), 32'h0);
      if (p == 21) chk("vsp", 32'(vs_out), 32'h1);
    end

    // Vsync edge coinciding with line start: parity clears, line undimmed.
    enable = 1'b1;
    for (int p = 0; p < 32; p++) begin
      set_pos(p, 32);
      if (p == 0) vs_in = 1'b0;
      step();
      if (p == 5) chk("sim_odd", 32'(line_odd), 32'h0);
      if (p == 16) chk("sim_r", 32'(r_out), 32'hF);
    end
    run_line(32, 4'h3);

    // Blanking: colour forced to zero, de follows blanks with 2-cycle latency.
    enable = 1'b0;
    hs_in = 1'b1; hbl_in = 1'b1; vbl_in = 1'b0;
    r_in = 4'hA; g_in = 4'hA; b_in = 4'hA;
    repeat (3) step();
    chk("hbl_de", 32'(de_out), 32'h0);
    chk("hbl_r",  32'(r_out),  32'h0);
    hbl_in = 1'b0;
    step();
    chk("de_rise_early", 32'(de_out), 32'h0);
    step();
    chk("de_rise", 32'(de_out), 32'h1);
    chk("de_rise_r", 32'(r_out), 32'hA);
    vbl_in = 1'b1;
    repeat (2) step();
    chk("vbl_de", 32'(de_out), 32'h0);
    chk("vbl_g",  32'(g_out),  32'h0);
    vbl_in = 1'b0;

    // Mixed colours at 25 %: 9 -> 7 on the odd line.
    enable = 1'b1; scanlines = 2'd1;
    r_in = 4'h9; g_in = 4'h6; b_in = 4'h1;
    run_line(32, 4'h9);
    run_line(32, 4'h7);

    // Reset mid-line: first line start afterwards gives an odd line.
    for (int p = 0; p < 32; p++) begin
      set_pos(p, 32);
      reset_n = (p == 15) ? 1'b0 : 1'b1;
      step();
      if (p == 15) chk("mrst_odd", 32'(line_odd), 32'h0);
    end
    reset_n = 1'b1;
    for (int p = 0; p < 32; p++) begin
      set_pos(p, 32);
      step();
      if (p == 5) chk("mrst_line1", 32'(line_odd), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_scanlines.md
Name: video_scanlines

Overview:
- Post-processing stage placed directly after the line doubler, on its output bus (hs/vs/hbl/vbl/RGB at doubled line rate).
- Darkens every second output line to emulate CRT scanlines, with the strength selectable.
- Delays vsync by one output line, quantised to line starts.
- Generates a registered data-enable and forces colour to zero during blanking.
- Feeds the scaler/video output; one clock, fixed latency.

Parameters:
- COLOR_DEPTH, 4, bits per colour channel.

Ports:
- clk_sys  in  1  system clock; every register updates on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  1 = scanline dimming and vsync delay active; 0 = timing-matched pass-through.
- scanlines  in  2  dim strength: 0 = off, 1 = 25 %, 2 = 50 %, 3 = 75 %.
- hs_in  in  1  hsync; a 1→0 transition marks line start.
- vs_in  in  1  vsync, either polarity.
- hbl_in  in  1  horizontal blank, active high.
- vbl_in  in  1  vertical blank, active high.
- r_in, g_in, b_in  in  COLOR_DEPTH each  pixel colour.
- hs_out  out  1  hsync delayed by 2 cycles.
- vs_out  out  1  vsync, delayed (see Behaviour).
- de_out  out  1  data enable = ~(hbl|vbl), aligned with the colour outputs.
- r_out, g_out, b_out  out  COLOR_DEPTH each  processed colour.
- line_odd  out  1  parity of the current output line (status/debug).

Behaviour:
- Reset (reset_n = 0 at a clock edge): hs_out = 1, vs_out = 1, de_out = 0, RGB outputs = 0, line_odd = 0; internal vs delay registers = 1; latched dim mode = 0; edge-detect history registers = 1.
- Stage 1: register all inputs into hs1, vs1, hbl1, vbl1, rgb1.
- Edge detection, evaluated on stage-1 values:
  - line_start = hs1_prev & ~hs1.
  - vs_edge = vs1_prev ≠ vs1.
- Line parity:
  - At line_start, line_odd toggles.
  - At vs_edge, line_odd is cleared to 0.
  - When both occur in the same cycle, the clear wins: line_odd = 0.
- Dim mode latch: at line_start, mode_l <= scanlines. A change of scanlines mid-line never affects the current line.
- Vsync delay (enable = 1):
  - At line_start: vs_out <= vs_hold and vs_hold <= vs1.
  - Between line starts, vs_out holds its value.
  - Result: vs_out changes only at line starts, one line later than it would in an undelayed stream.
  - With no line starts, vs_out freezes. This is required and is not an error.
- Stage 2 outputs, registered:
  - hs_out <= hs1.
  - de_out <= ~(hbl1|vbl1).
  - If ~de, RGB = 0.
  - Else if enable & line_odd & (mode_l ≠ 0), each channel c is replaced by dim(c, mode_l).
  - Otherwise c passes unchanged.
- dim(c, m), COLOR_DEPTH-bit unsigned, truncating, no rounding:
  - m = 1: c − (c >> 2).
  - m = 2: c >> 1.
  - m = 3: c >> 2.
  - Result never exceeds c, so no overflow.
- Latency: 2 clk_sys cycles from input to output for hs, de and RGB.
- enable = 0:
  - vs_out <= vs1, giving 2-cycle latency and no line delay.
  - No dimming.
  - Parity and mode tracking continue, so re-enabling mid-frame is glitch-free from the next line.
- Toggling enable:
  - The vs_out source switches immediately.
  - vs_hold is always updated at line_start regardless of enable.
- Reset asserted mid-line: all state returns to its reset values on that edge.
  - After release, the first line_start sets line_odd = 1.

Decomposition:
- Shared package video_pkg holds:
  - Constants SL_OFF = 2'd0, SL_25 = 2'd1, SL_50 = 2'd2, SL_75 = 2'd3.
  - PIPE_LAT = 2.
- Sub-module video_dim (parameter COLOR_DEPTH): combinational, one channel. Inputs c and m; output dimmed c. Instantiated three times.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles with random inputs → hs_out = 1, vs_out = 1, de_out = 0, RGB = 0, line_odd = 0. After release, input colour appears 2 cycles later.
- Dimming, scanlines = 2, enable = 1, constant r = g = b = 4'hF, de active:
  - Even lines output 4'hF; odd lines output 4'h7.
  - With scanlines = 1, odd lines output 4'hC; with scanlines = 3, odd lines output 4'h3.
- Mid-line mode change: switch scanlines from 1 to 3 in the middle of an odd line → rest of that line stays 4'hC; the next odd line outputs 4'h3.
- Vsync delay: toggle vs_in 100 cycles after line start N with enable = 1 → vs_out changes exactly 2 cycles after line start N+2 (and not earlier). With enable = 0 → vs_out changes 2 cycles after vs_in.
- Simultaneous events: vs_in edge and hs_in falling edge in the same cycle → line_odd = 0 afterwards, and the next line is undimmed.
- Blanking: hbl_in = 1 with r = 4'hA → RGB outputs = 0 and de_out = 0, both 2 cycles later. On hbl_in 1→0, de_out rises exactly 2 cycles later.
